// File: rtl/alu_mul_sequencer_if.sv
// Bundle between the multiply sequencer and the execute stage: request/result
// handshake plus the ALU operand/operation lines the sequencer owns while busy.
interface alu_mul_sequencer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_zero;
  logic [3:0]            alu_operation;
  logic [DATA_WIDTH-1:0] alu_a;
  logic [DATA_WIDTH-1:0] alu_b;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] product;

  // Execute-stage side: issues requests and returns the ALU's answers.
  modport master (
    output start, op_a, op_b, alu_result, alu_zero,
    input  alu_operation, alu_a, alu_b, busy, done, product
  );

  modport slave (
    input  start, op_a, op_b, alu_result, alu_zero,
    output alu_operation, alu_a, alu_b, busy, done, product
  );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Shift-add 32x32 multiplier (low 32 bits) that borrows the shared ALU for
// every add and shift; the datapath hands the ALU to this block while busy.
module alu_mul_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter bit EARLY_EXIT = 1'b1
) (
  input logic               clk,
  input logic               reset,
  alu_mul_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADD,
    S_SHL,
    S_SHR,
    S_DONE
  } state_e;

  localparam logic [3:0]            OP_NONE   = 4'b0000;
  localparam logic [3:0]            OP_ADD    = 4'b0011;
  localparam logic [3:0]            OP_SLL    = 4'b1000;
  localparam logic [3:0]            OP_SRL    = 4'b1001;
  localparam logic [5:0]            LAST_ITER = 6'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] ONE       = DATA_WIDTH'(1);

  state_e                state_q;
  logic [DATA_WIDTH-1:0] mcand_q;
  logic [DATA_WIDTH-1:0] mplier_q;
  logic [DATA_WIDTH-1:0] acc_q;
  logic [DATA_WIDTH-1:0] product_q;
  logic [5:0]            iter_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  last_iter;

  // The shifted multiplier comes straight back from the ALU, so its Zero flag
  // tells us the remaining bits are all clear without a separate compare.
  assign last_iter = EARLY_EXIT ? bus.alu_zero : (iter_q == LAST_ITER);

  // NOTE: every variable driven here gets a default first, so no latch is inferred.
  always_comb begin
    bus.alu_operation = OP_NONE;
    bus.alu_a         = '0;
    bus.alu_b         = '0;
    unique case (state_q)
      S_ADD: begin
        bus.alu_operation = OP_ADD;
        bus.alu_a         = acc_q;
        bus.alu_b         = mcand_q;
      end
      S_SHL: begin
        bus.alu_operation = OP_SLL;
        bus.alu_a         = mcand_q;
        bus.alu_b         = ONE;
      end
      S_SHR: begin
        bus.alu_operation = OP_SRL;
        bus.alu_a         = mplier_q;
        bus.alu_b         = ONE;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      product_q <= '0;
      iter_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            mcand_q  <= bus.op_a;
            mplier_q <= bus.op_b;
            acc_q    <= '0;
            iter_q   <= '0;
            busy_q   <= 1'b1;
            if (EARLY_EXIT && (bus.op_b == '0)) begin
              state_q   <= S_DONE;
              done_q    <= 1'b1;
              product_q <= '0;
            end else if (bus.op_b[0]) begin
              state_q <= S_ADD;
            end else begin
              state_q <= S_SHL;
            end
          end
        end
        S_ADD: begin
          acc_q   <= bus.alu_result;
          state_q <= S_SHL;
        end
        S_SHL: begin
          mcand_q <= bus.alu_result;
          state_q <= S_SHR;
        end
        S_SHR: begin
          mplier_q <= bus.alu_result;
          iter_q   <= iter_q + 6'd1;
          if (last_iter) begin
            state_q   <= S_DONE;
            done_q    <= 1'b1;
            product_q <= acc_q;
          end else if (bus.alu_result[0]) begin
            state_q <= S_ADD;
          end else begin
            state_q <= S_SHL;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;

endmodule
